// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/grant encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;
  localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, bit0=IF bit1=D, last-served register updated on upd
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);
  logic last_d;
  always_comb gnt = (req == 2'b11) ? (last_d ? GNT_IF : GNT_D) : req;
  always_ff @(posedge clk or negedge clr)
    if (!clr) last_d <= 1'b0;
    else if (upd && gnt != GNT_NONE) last_d <= gnt[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters
// with round-robin arbitration, ready handshake, timeout and done pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic [1:0]          grant
);
  state_t state, state_n;
  logic [1:0] pick, gnt_q;
  logic we_q, err_q, start, hit, expire;
  logic [7:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  assign start  = (state == IDLE) && (if_req || d_req);
  assign hit    = (state == ACCESS) && mem_ready;
  assign expire = (state == ACCESS) && (cnt == 8'(TIMEOUT));
  rr_arb2 u_arb (.clk(clk), .clr(clr), .req({d_req, if_req}), .upd(start), .gnt(pick));
  always_ff @(posedge clk or negedge clr)
    if (!clr) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (start ? ACCESS : IDLE) :
              (state == ACCESS) ? ((hit || expire) ? RESP : ACCESS) : IDLE;
  end
  // Strobes and done derive only from registered state, so clr drops them at once.
  assign mem_read  = (state == ACCESS) && !we_q;
  assign mem_write = (state == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign busy      = state != IDLE;
  assign grant     = gnt_q;
  assign if_done   = (state == RESP) && (gnt_q == GNT_IF);
  assign d_done    = (state == RESP) && (gnt_q == GNT_D);
  assign if_err    = if_done && err_q;
  assign d_err     = d_done && err_q;
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      gnt_q    <= GNT_NONE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= 8'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      cnt <= (state == ACCESS && !(hit || expire)) ? cnt + 8'd1 : 8'd0;
      if (start) begin
        gnt_q   <= pick;
        addr_q  <= (pick == GNT_D) ? d_addr : if_addr;
        we_q    <= (pick == GNT_D) && d_we;
        wdata_q <= (pick == GNT_D) ? d_wdata : '0;
        wstrb_q <= (pick == GNT_D) ? d_wstrb : '0;
      end
      if (state == RESP) gnt_q <= GNT_NONE;
      if (hit || expire) err_q <= !hit;
      if (hit && gnt_q == GNT_IF) if_rdata <= mem_rdata;
      if (hit && gnt_q == GNT_D && !we_q) d_rdata <= mem_rdata;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multicycle RV32 core between two requesters: instruction fetch (IF) and data load/store (D).
- The multicycle control FSM drives both requester ports.
- Arbitrates, latches the winning request, runs a variable-latency ready handshake to memory, and returns one done pulse with read data or error.
- Sits between the control/datapath and the memory, in place of direct MemoryRead/MemoryWrite wiring.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte strobes = DATA_W/8)
TIMEOUT, 15, max ACCESS cycles waiting for mem_ready before abort (1..255)

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous active-low reset (clr=0 resets)
if_req  in  1  fetch request, level, held until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch data, valid with if_done
if_done  out  1  one-cycle completion pulse
if_err  out  1  timeout flag, valid with if_done
d_req  in  1  data request, level, held until d_done
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  store byte enables
d_rdata  out  DATA_W  load data, valid with d_done
d_done  out  1  one-cycle completion pulse
d_err  out  1  timeout flag, valid with d_done
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte enables
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completion, sampled only while a strobe is high
busy  out  1  state != IDLE
grant  out  2  01=IF owns port, 10=D owns port, 00=none

Behaviour:
- Reset (clr=0, async):
  - State IDLE.
  - All outputs 0, including rdata registers.
  - Timeout counter 0; round-robin pointer last=IF.
- FSM:
  - IDLE -> ACCESS when any req is high.
  - ACCESS -> RESP on mem_ready=1, or when the timeout counter reaches TIMEOUT.
  - RESP -> IDLE unconditionally.
- Arbitration in IDLE:
  - Only one req high: that requester wins.
  - Both high: the one not served last wins. Pointer updates on grant.
- Grant edge (IDLE->ACCESS):
  - Latch address, we, wdata, wstrb. IF is always a read with wstrb=0.
  - grant is set and held through RESP.
  - Requester inputs are ignored after the latch.
- ACCESS:
  - mem_read = !we or mem_write = we, from registered state (no combinational path from req).
  - mem_addr, mem_wdata, mem_wstrb are driven from the latched values.
  - Counter increments each ACCESS cycle.
- mem_ready=1 in ACCESS:
  - Capture mem_rdata into the granted requester's rdata register. Stores leave rdata unchanged.
  - Go to RESP; strobes drop in RESP.
- Timeout: counter==TIMEOUT with no mem_ready -> RESP with err=1; rdata unchanged.
- mem_ready and timeout in the same cycle: ready wins, err=0.
- RESP:
  - Exactly one of if_done/d_done = 1 for one cycle; matching err valid.
  - Counter cleared.
  - rdata registers hold until the next capture for that requester.
- Latency:
  - Request at IDLE edge n: strobe in cycle n+1.
  - Zero-wait memory (mem_ready in the first ACCESS cycle): done in cycle n+2.
  - With k wait cycles: done at n+2+k.
- Back-to-back:
  - A requester still holding req after its done is treated as a new request in the following IDLE.
  - Both continuously requesting alternate IF, D, IF, ...
- Ignored inputs:
  - mem_ready outside ACCESS.
  - req deassertion during ACCESS; the transaction completes and done still pulses.
- clr asserted mid-transaction:
  - Immediate abort, strobes drop asynchronously, no done pulse.
- Store with d_wstrb=0 is still issued as a write.
- Alignment is not checked.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/RESP), grant encodings GNT_NONE/GNT_IF/GNT_D, default TIMEOUT.
- One sub-module, rr_arb2: 2-way round-robin picker with a last-served register, combinational grant output, and an update enable.

Test Plan:
- Reset, then if_req=1, if_addr=0x00000010, mem_ready=1 in the first ACCESS cycle, mem_rdata=0x00500093 -> mem_read high 1 cycle, if_done at cycle 2 with if_rdata=0x00500093, if_err=0.
- d_req store, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=0xF, mem_ready after 3 wait cycles -> mem_write high 4 cycles, d_done at cycle 5, d_rdata unchanged.
- if_req and d_req both held high with zero-wait memory -> grant sequence 10,01,10,01 (D first after reset), one done every 3 cycles.
- mem_ready never asserted, TIMEOUT=15 -> strobe high 16 cycles, then done with err=1, then IDLE.
- clr pulled low for 1 cycle mid-ACCESS -> strobes and grant drop immediately, no done; a fresh request after release completes normally.
- mem_ready pulsed while IDLE, plus req dropped during ACCESS -> no spurious done from the idle pulse; the in-flight transaction still completes with done.
